// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared FSM state encoding and error counter width
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// rtl/serial_parity_checker_parity_acc.sv - 1-bit XOR accumulator producing the expected parity bit
module parity_acc #(
    parameter int ODD_PARITY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic parity_exp
);

    localparam logic INVERT = (ODD_PARITY != 0);

    logic acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

    assign parity_exp = acc ^ INVERT;

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver with parity check; PARITY_ERR_CNT_EN adds err_count
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_valid,
    output logic                 parity_err,
    output logic                 busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_exp;
    logic                 restart;
    logic                 shift_en;
    logic                 capture;

    parity_acc #(
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .en         (shift_en),
        .bit_in     (bit_in),
        .parity_exp (parity_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start wins over bit_valid in every state, so an in-flight frame is dropped.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DATA;
                    restart    = 1'b1;
                end
            end
            DATA: begin
                if (start) begin
                    next_state = DATA;
                    restart    = 1'b1;
                end else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_IDX) begin
                        next_state = PARITY;
                    end
                end
            end
            PARITY: begin
                if (start) begin
                    next_state = DATA;
                    restart    = 1'b1;
                end else if (bit_valid) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = DATA;
                    restart    = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shift_reg <= '0;
        end else begin
            if (restart) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (shift_en) begin
                shift_reg <= {bit_in, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // Results are registered as the parity bit arrives so they are valid during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            parity_err <= 1'b0;
        end else if (capture) begin
            data_out   <= shift_reg;
            parity_err <= (bit_in != parity_exp);
        end
    end

    assign frame_valid = (state == DONE);
    assign busy        = (state == DATA) || (state == PARITY);

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (frame_valid && parity_err && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - directed self-checking bench for serial_parity_checker (odd and even instances)
module tb_serial_parity_checker;
    import serial_parity_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] data_out, data_out_e;
    logic       frame_valid, frame_valid_e;
    logic       parity_err, parity_err_e;
    logic       busy, busy_e;
`ifdef PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_count, err_count_e;
`endif

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;
    int fv0;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out), .frame_valid(frame_valid), .parity_err(parity_err), .busy(busy)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(err_count)
`endif
    );

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out_e), .frame_valid(frame_valid_e), .parity_err(parity_err_e), .busy(busy_e)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(err_count_e)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt <= fv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle of inputs; returns 1ns after the sampling edge.
    task automatic cyc(input logic s, input logic v, input logic b);
        start     = s;
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input int gap);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, d[i]);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, ~d[i]);
        end
        cyc(1'b0, 1'b1, par);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_frame_valid", frame_valid, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Good frame 0xA5 with odd parity bit 1
        fv0 = fv_cnt;
        send_frame(8'hA5, 1'b1, 0);
        check("a5_frame_valid", frame_valid, 1'b1);
        check("a5_data_out", data_out, 8'hA5);
        check("a5_parity_err", parity_err, 1'b0);
        check("a5_busy_in_done", busy, 1'b0);
`ifdef PARITY_ERR_CNT_EN
        check("a5_err_count", err_count, 8'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0);
        check("a5_pulse_ends", frame_valid, 1'b0);
        check("a5_single_pulse", fv_cnt - fv0, 1);

        // Same data, wrong parity
        send_frame(8'hA5, 1'b0, 0);
        check("a5bad_frame_valid", frame_valid, 1'b1);
        check("a5bad_parity_err", parity_err, 1'b1);
        check("a5bad_even_err", parity_err_e, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("a5bad_err_held", parity_err, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        check("a5bad_err_count", err_count, 8'd1);
`endif

        // 0x3C with two idle cycles after every data bit
        fv0 = fv_cnt;
        send_frame(8'h3C, 1'b1, 2);
        check("gap_frame_valid", frame_valid, 1'b1);
        check("gap_data_out", data_out, 8'h3C);
        check("gap_parity_err", parity_err, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("gap_single_pulse", fv_cnt - fv0, 1);

        // Abort after 4 bits, then a full 0xFF frame
        fv0 = fv_cnt;
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        check("abort_busy_mid", busy, 1'b1);
        send_frame(8'hFF, 1'b1, 0);
        check("abort_frame_valid", frame_valid, 1'b1);
        check("abort_data_out", data_out, 8'hFF);
        check("abort_parity_err", parity_err, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("abort_single_pulse", fv_cnt - fv0, 1);

        // Abort leaves previous results untouched
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("abort_data_hold", data_out, 8'hFF);
        check("abort_err_hold", parity_err, 1'b0);

        // 0xFF with parity 0: wrong for odd, right for even
        send_frame(8'hFF, 1'b0, 0);
        check("ff0_odd_err", parity_err, 1'b1);
        check("ff0_even_data", data_out_e, 8'hFF);
        check("ff0_even_err", parity_err_e, 1'b0);
        check("ff0_even_valid", frame_valid_e, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // Asynchronous reset after 5 bits
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        check("arst_busy", busy, 1'b0);
        check("arst_data_out", data_out, 8'h00);
        check("arst_parity_err", parity_err, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fv0 = fv_cnt;
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("arst_no_frame", fv_cnt - fv0, 0);
        check("arst_idle_busy", busy, 1'b0);
        send_frame(8'h5A, 1'b1, 0);
        check("arst_new_valid", frame_valid, 1'b1);
        check("arst_new_data", data_out, 8'h5A);
        check("arst_new_err", parity_err, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // bit_valid in the start cycle must be ignored
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
        check("startbit_not_early", frame_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check("startbit_valid", frame_valid, 1'b1);
        check("startbit_data", data_out, 8'h00);
        check("startbit_err", parity_err, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

`ifdef PARITY_ERR_CNT_EN
        check("cnt_after_reset", err_count, 8'd0);
        for (int n = 0; n < 260; n++) send_frame(8'hA5, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("cnt_saturated", err_count, 8'd255);
        send_frame(8'h00, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("cnt_held", err_count, 8'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
